// File: rtl/itch_tx_serializer_if.sv
// -----------------------------------------------------------------------------
// itch_tx_serializer_if
// Bundles the message-capture bus and the byte-wide TX stream of the ITCH
// add-order serializer.
//   master : producer of i_valid/i_reg_1..7 and consumer of the byte stream
//   slave  : the serializer itself
// Signals:
//   i_valid, i_reg_1..i_reg_7  one packed add-order message per i_valid cycle
//   o_tdata/o_tvalid/o_tlast   frame byte stream, i_tready is the backpressure
//   o_full                     message FIFO full
//   o_drop_count               saturating count of messages dropped
// -----------------------------------------------------------------------------
interface itch_tx_serializer_if #(
    parameter int REG_WIDTH      = 32,
    parameter int DROP_CNT_WIDTH = 16
);
    logic                      i_valid;
    logic [REG_WIDTH-1:0]      i_reg_1;
    logic [REG_WIDTH-1:0]      i_reg_2;
    logic [REG_WIDTH-1:0]      i_reg_3;
    logic [REG_WIDTH-1:0]      i_reg_4;
    logic [REG_WIDTH-1:0]      i_reg_5;
    logic [REG_WIDTH-1:0]      i_reg_6;
    logic [REG_WIDTH-1:0]      i_reg_7;
    logic [7:0]                o_tdata;
    logic                      o_tvalid;
    logic                      i_tready;
    logic                      o_tlast;
    logic                      o_full;
    logic [DROP_CNT_WIDTH-1:0] o_drop_count;

    modport master (
        output i_valid, i_reg_1, i_reg_2, i_reg_3, i_reg_4, i_reg_5, i_reg_6,
               i_reg_7, i_tready,
        input  o_tdata, o_tvalid, o_tlast, o_full, o_drop_count
    );

    modport slave (
        input  i_valid, i_reg_1, i_reg_2, i_reg_3, i_reg_4, i_reg_5, i_reg_6,
               i_reg_7, i_tready,
        output o_tdata, o_tvalid, o_tlast, o_full, o_drop_count
    );
endinterface

// File: rtl/itch_tx_serializer.sv
// -----------------------------------------------------------------------------
// itch_tx_serializer
// Buffers whole add-order messages in a small FIFO and serializes each one,
// big-endian, into a 26-byte ITCH-style frame on a valid/ready byte stream.
// Upstream cannot be stalled, so messages arriving with the FIFO full are
// dropped whole and counted.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   bus      itch_tx_serializer_if.slave (message input, byte stream output,
//            full flag and drop counter)
// -----------------------------------------------------------------------------
module itch_tx_serializer #(
    parameter int REG_WIDTH      = 32,
    parameter int MSG_DEPTH      = 2,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    itch_tx_serializer_if.slave  bus
);
    localparam int FRAME_W = 208;
    localparam int AW      = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;

    localparam logic [AW:0]               DEPTH_C    = (AW+1)'(MSG_DEPTH);
    localparam logic [AW:0]               CNT_ZERO_C = (AW+1)'(0);
    localparam logic [AW:0]               CNT_ONE_C  = (AW+1)'(1);
    localparam logic [AW-1:0]             PTR_ONE_C  = AW'(1);
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE_C = DROP_CNT_WIDTH'(1);
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX_C = {DROP_CNT_WIDTH{1'b1}};
    localparam logic [4:0]                LAST_IDX_C = 5'd25;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    // Lays out the 26 frame bytes, byte 0 in the top bits.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] r3,
        input logic [31:0] r4, input logic [31:0] r5, input logic [31:0] r6,
        input logic [31:0] r7
    );
        logic [7:0] side_char;
        side_char = r1[0] ? 8'h53 : 8'h42;
        return {r1[8:1], r2, r3, side_char, r4, r5, r6, r7};
    endfunction

    logic [FRAME_W-1:0]        mem_r [MSG_DEPTH];
    logic [AW-1:0]             wr_ptr_r;
    logic [AW-1:0]             rd_ptr_r;
    logic [AW:0]               count_r;
    logic [FRAME_W-1:0]        frame_r;
    logic [4:0]                idx_r;
    logic [7:0]                tdata_r;
    logic                      tvalid_r;
    logic                      tlast_r;
    logic                      full_r;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_r;
    state_t                    state_r;

    logic [FRAME_W-1:0]        in_frame_s;
    logic [FRAME_W-1:0]        src_frame_s;
    logic                      hs_s;
    logic                      last_hs_s;
    logic                      push_ok_s;
    logic                      drop_s;
    logic                      load_s;
    logic                      bypass_s;
    logic                      pop_s;
    logic                      wr_s;
    logic [AW:0]               count_n_s;
    state_t                    state_n_s;
    logic [4:0]                idx_n_s;
    logic [7:0]                tdata_n_s;
    logic                      tvalid_n_s;
    logic                      tlast_n_s;
    logic [FRAME_W-1:0]        frame_n_s;
    logic                      unused_reg1_s;

    assign in_frame_s = build_frame(bus.i_reg_1[31:0], bus.i_reg_2[31:0],
                                    bus.i_reg_3[31:0], bus.i_reg_4[31:0],
                                    bus.i_reg_5[31:0], bus.i_reg_6[31:0],
                                    bus.i_reg_7[31:0]);
    assign unused_reg1_s = ^bus.i_reg_1[REG_WIDTH-1:9];

    // Admission, hold-register load and FIFO push/pop decisions.
    // The hold register is refilled on the final-byte handshake (its content
    // is no longer needed), so a push accepted against a full FIFO in that
    // cycle always finds the head slot freed. If the FIFO is empty at that
    // moment, the same-cycle message bypasses the FIFO straight into the hold
    // register so the one-cycle LOAD gap is preserved.
    always_comb begin
        hs_s      = tvalid_r & bus.i_tready;
        last_hs_s = hs_s & tlast_r;
        push_ok_s = bus.i_valid & ((count_r < DEPTH_C) | last_hs_s);
        drop_s    = bus.i_valid & ~push_ok_s;
        if (state_r == ST_IDLE) begin
            load_s = (count_r != CNT_ZERO_C);
        end else if (state_r == ST_SEND) begin
            load_s = last_hs_s & ((count_r != CNT_ZERO_C) | push_ok_s);
        end else begin
            load_s = 1'b0;
        end
        bypass_s    = load_s & (count_r == CNT_ZERO_C);
        pop_s       = load_s & ~bypass_s;
        wr_s        = push_ok_s & ~bypass_s;
        src_frame_s = bypass_s ? in_frame_s : mem_r[rd_ptr_r];
        count_n_s   = count_r;
        if (wr_s && !pop_s) begin
            count_n_s = count_r + CNT_ONE_C;
        end else if (pop_s && !wr_s) begin
            count_n_s = count_r - CNT_ONE_C;
        end else begin
            count_n_s = count_r;
        end
    end

    // Next-state and next-output logic of the serializer FSM.
    always_comb begin
        state_n_s  = state_r;
        idx_n_s    = idx_r;
        tdata_n_s  = tdata_r;
        tvalid_n_s = tvalid_r;
        tlast_n_s  = tlast_r;
        frame_n_s  = frame_r;
        case (state_r)
            ST_IDLE: begin
                tvalid_n_s = 1'b0;
                tlast_n_s  = 1'b0;
                tdata_n_s  = 8'h00;
                if (load_s) begin
                    state_n_s = ST_LOAD;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_n_s  = ST_SEND;
                idx_n_s    = 5'd0;
                tvalid_n_s = 1'b1;
                tlast_n_s  = 1'b0;
                tdata_n_s  = frame_r[FRAME_W-1 -: 8];
                frame_n_s  = {frame_r[FRAME_W-9:0], 8'h00};
            end
            ST_SEND: begin
                if (hs_s && (idx_r == LAST_IDX_C)) begin
                    tvalid_n_s = 1'b0;
                    tlast_n_s  = 1'b0;
                    tdata_n_s  = 8'h00;
                    state_n_s  = load_s ? ST_LOAD : ST_IDLE;
                end else if (hs_s) begin
                    idx_n_s   = idx_r + 5'd1;
                    tdata_n_s = frame_r[FRAME_W-1 -: 8];
                    frame_n_s = {frame_r[FRAME_W-9:0], 8'h00};
                    tlast_n_s = (idx_r == (LAST_IDX_C - 5'd1));
                end else begin
                    state_n_s = ST_SEND;
                end
            end
            default: begin
                state_n_s  = ST_IDLE;
                idx_n_s    = 5'd0;
                tvalid_n_s = 1'b0;
                tlast_n_s  = 1'b0;
                tdata_n_s  = 8'h00;
            end
        endcase
        if (load_s) begin
            frame_n_s = src_frame_s;
        end else begin
            frame_n_s = frame_n_s;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Datapath, FIFO bookkeeping, output and drop-counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= CNT_ZERO_C;
            frame_r    <= {FRAME_W{1'b0}};
            idx_r      <= 5'd0;
            tdata_r    <= 8'h00;
            tvalid_r   <= 1'b0;
            tlast_r    <= 1'b0;
            full_r     <= 1'b0;
            drop_cnt_r <= {DROP_CNT_WIDTH{1'b0}};
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            count_r  <= count_n_s;
            full_r   <= (count_n_s == DEPTH_C);
            frame_r  <= frame_n_s;
            idx_r    <= idx_n_s;
            tdata_r  <= tdata_n_s;
            tvalid_r <= tvalid_n_s;
            tlast_r  <= tlast_n_s;
            if (drop_s && (drop_cnt_r != DROP_MAX_C)) begin
                drop_cnt_r <= drop_cnt_r + DROP_ONE_C;
            end
        end
    end

    // Message storage; contents need no reset since count gates every read.
    always_ff @(posedge i_clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= in_frame_s;
        end
    end

    assign bus.o_tdata      = tdata_r;
    assign bus.o_tvalid     = tvalid_r;
    assign bus.o_tlast      = tlast_r;
    assign bus.o_full       = full_r;
    assign bus.o_drop_count = drop_cnt_r;
endmodule

// File: tb/tb_itch_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_itch_tx_serializer
// Directed bench for itch_tx_serializer: a negedge monitor collects handshaken
// bytes, tlast flags and inter-frame gaps, and checks stall stability; the main
// sequence drives messages and compares against hand-derived frames.
// -----------------------------------------------------------------------------
module tb_itch_tx_serializer;
    localparam logic [207:0] BASE_FRAME =
        208'h0A_00000300_000003BA_42_000001BB_4141504C_20202020_0000BABB;

    logic i_clk = 1'b0;
    logic i_rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0] rx_q[$];
    logic       rxl_q[$];
    int         gap_q[$];

    bit         mon_in_frame;
    bit         mon_stalled;
    logic [7:0] mon_held_data;
    logic       mon_held_last;
    int         mon_gap;

    itch_tx_serializer_if #(.REG_WIDTH(32), .DROP_CNT_WIDTH(16)) bus ();

    itch_tx_serializer #(
        .REG_WIDTH(32), .MSG_DEPTH(2), .DROP_CNT_WIDTH(16)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [207:0] got, input logic [207:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [207:0] exp_frame(input bit side, input int k);
        logic [207:0] f;
        f = BASE_FRAME;
        f[143 -: 8] = 8'hBA + 8'(k);
        f[135 -: 8] = side ? 8'h53 : 8'h42;
        return f;
    endfunction

    task automatic drive_msg(input bit side, input int k, input logic [31:0] r1_hi);
        bus.i_valid = 1'b1;
        bus.i_reg_1 = r1_hi | (side ? 32'h0000_0015 : 32'h0000_0014);
        bus.i_reg_2 = 32'h0000_0300;
        bus.i_reg_3 = 32'h0000_03BA + 32'(k);
        bus.i_reg_4 = 32'h0000_01BB;
        bus.i_reg_5 = 32'h4141_504C;
        bus.i_reg_6 = 32'h2020_2020;
        bus.i_reg_7 = 32'h0000_BABB;
    endtask

    task automatic do_reset();
        bus.i_valid  = 1'b0;
        bus.i_tready = 1'b1;
        i_rst_n      = 1'b0;
        repeat (2) tick();
        i_rst_n = 1'b1;
        tick();
        rx_q.delete();
        rxl_q.delete();
        gap_q.delete();
    endtask

    // mode 1 drives i_tready with the repeating 1,0,0,1 pattern
    task automatic wait_bytes(input int n, input int mode);
        int c = 0;
        while (rx_q.size() < n && c < 2000) begin
            bus.i_tready = (mode == 1) ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            tick();
            c++;
        end
        bus.i_tready = 1'b1;
        repeat (4) tick();
        check("rx_count", 208'(rx_q.size()), 208'(n));
    endtask

    task automatic check_frame(input int f, input bit side, input int k);
        logic [207:0] got   = '0;
        logic [25:0]  lasts = '0;
        if (rx_q.size() >= 26 * (f + 1)) begin
            for (int i = 0; i < 26; i++) begin
                got   = {got[199:0], rx_q[26*f+i]};
                lasts = {lasts[24:0], rxl_q[26*f+i]};
            end
        end
        check($sformatf("frame%0d", f), got, exp_frame(side, k));
        check($sformatf("tlast%0d", f), 208'(lasts), 208'(26'd1));
    endtask

    task automatic check_gap(input int f);
        check($sformatf("gap%0d", f), 208'((gap_q.size() > f) ? gap_q[f] : -1), 208'(1));
    endtask

    // Byte monitor: records handshakes, checks stall stability and valid hold.
    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                mon_in_frame = 1'b0;
                mon_stalled  = 1'b0;
                mon_gap      = 0;
            end else begin
                if (mon_in_frame) check("tvalid_hold", 208'(bus.o_tvalid), 208'(1'b1));
                if (mon_stalled) begin
                    check("stall_data", 208'(bus.o_tdata), 208'(mon_held_data));
                    check("stall_last", 208'(bus.o_tlast), 208'(mon_held_last));
                end
                mon_stalled = 1'b0;
                if (bus.o_tvalid) begin
                    if (!mon_in_frame) begin
                        gap_q.push_back(mon_gap);
                        mon_in_frame = 1'b1;
                    end
                    if (bus.i_tready) begin
                        rx_q.push_back(bus.o_tdata);
                        rxl_q.push_back(bus.o_tlast);
                        if (bus.o_tlast) begin
                            mon_in_frame = 1'b0;
                            mon_gap      = 0;
                        end
                    end else begin
                        mon_stalled   = 1'b1;
                        mon_held_data = bus.o_tdata;
                        mon_held_last = bus.o_tlast;
                    end
                end else begin
                    mon_gap++;
                end
            end
        end
    end

    initial begin
        bit found;
        int c;
        i_rst_n      = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_tready = 1'b1;
        bus.i_reg_1  = 32'h0; bus.i_reg_2 = 32'h0; bus.i_reg_3 = 32'h0;
        bus.i_reg_4  = 32'h0; bus.i_reg_5 = 32'h0; bus.i_reg_6 = 32'h0;
        bus.i_reg_7  = 32'h0;

        // reset state
        do_reset();
        check("rst_tvalid", 208'(bus.o_tvalid), 208'(1'b0));
        check("rst_tlast",  208'(bus.o_tlast),  208'(1'b0));
        check("rst_tdata",  208'(bus.o_tdata),  208'(8'h00));
        check("rst_full",   208'(bus.o_full),   208'(1'b0));
        check("rst_drop",   208'(bus.o_drop_count), 208'(16'd0));

        // single buy message, latency of first byte
        drive_msg(1'b0, 0, 32'h0);
        tick();
        bus.i_valid = 1'b0;
        check("lat_idle", 208'(bus.o_tvalid), 208'(1'b0));
        tick();
        check("lat_load", 208'(bus.o_tvalid), 208'(1'b0));
        tick();
        check("lat_first_valid", 208'(bus.o_tvalid), 208'(1'b1));
        check("lat_first_byte",  208'(bus.o_tdata),  208'(8'h0A));
        wait_bytes(26, 0);
        check_frame(0, 1'b0, 0);
        check("idle_after", 208'(bus.o_tvalid), 208'(1'b0));

        // sell side with 1,0,0,1 backpressure
        do_reset();
        drive_msg(1'b1, 0, 32'h0);
        tick();
        bus.i_valid = 1'b0;
        wait_bytes(26, 1);
        check_frame(0, 1'b1, 0);

        // overflow: five messages against a stalled sink
        do_reset();
        bus.i_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_msg(1'b0, k, 32'h0);
            tick();
        end
        bus.i_valid = 1'b0;
        tick();
        check("ovf_full", 208'(bus.o_full), 208'(1'b1));
        check("ovf_drop", 208'(bus.o_drop_count), 208'(16'd2));
        wait_bytes(78, 0);
        for (int f = 0; f < 3; f++) check_frame(f, 1'b0, f);
        check("ovf_full_after", 208'(bus.o_full), 208'(1'b0));
        check("ovf_drop_after", 208'(bus.o_drop_count), 208'(16'd2));

        // push coinciding with the final-byte handshake while full
        do_reset();
        bus.i_tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_msg(1'b0, k, 32'h0);
            tick();
        end
        bus.i_valid = 1'b0;
        repeat (2) tick();
        check("sim_full_pre", 208'(bus.o_full), 208'(1'b1));
        bus.i_tready = 1'b1;
        found = 1'b0;
        c = 0;
        while (!found && c < 200) begin
            if (bus.o_tvalid && bus.o_tlast) found = 1'b1;
            else tick();
            c++;
        end
        check("sim_found_last", 208'(found), 208'(1'b1));
        drive_msg(1'b0, 3, 32'h0);
        tick();
        bus.i_valid = 1'b0;
        check("sim_drop",      208'(bus.o_drop_count), 208'(16'd0));
        check("sim_full_post", 208'(bus.o_full),   208'(1'b1));
        check("sim_load_gap",  208'(bus.o_tvalid), 208'(1'b0));
        tick();
        check("sim_next_valid", 208'(bus.o_tvalid), 208'(1'b1));
        wait_bytes(104, 0);
        for (int f = 0; f < 4; f++) check_frame(f, 1'b0, f);
        for (int f = 1; f < 4; f++) check_gap(f);
        check("sim_drop_end", 208'(bus.o_drop_count), 208'(16'd0));

        // back-to-back messages 27 cycles apart; message 2 carries junk high bits
        do_reset();
        for (int m = 0; m < 4; m++) begin
            drive_msg(m[0], m, (m == 2) ? 32'hFFFF_FE00 : 32'h0);
            tick();
            bus.i_valid = 1'b0;
            repeat (26) tick();
        end
        wait_bytes(104, 0);
        for (int f = 0; f < 4; f++) check_frame(f, f[0], f);
        for (int f = 1; f < 4; f++) check_gap(f);
        check("b2b_drop", 208'(bus.o_drop_count), 208'(16'd0));

        // reset in the middle of a frame
        do_reset();
        drive_msg(1'b0, 0, 32'h0);
        tick();
        bus.i_valid = 1'b0;
        c = 0;
        while (rx_q.size() < 12 && c < 100) begin
            tick();
            c++;
        end
        check("mid_reached", 208'(rx_q.size()), 208'(12));
        check("mid_byte12", 208'(bus.o_tdata), 208'(8'h01));
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", 208'(bus.o_tvalid), 208'(1'b0));
        check("mid_rst_tlast",  208'(bus.o_tlast),  208'(1'b0));
        check("mid_rst_tdata",  208'(bus.o_tdata),  208'(8'h00));
        repeat (2) tick();
        i_rst_n = 1'b1;
        repeat (3) tick();
        check("mid_post_tvalid", 208'(bus.o_tvalid), 208'(1'b0));
        check("mid_post_drop",   208'(bus.o_drop_count), 208'(16'd0));
        check("mid_post_full",   208'(bus.o_full),   208'(1'b0));
        rx_q.delete();
        rxl_q.delete();
        gap_q.delete();
        drive_msg(1'b1, 5, 32'h0);
        tick();
        bus.i_valid = 1'b0;
        wait_bytes(26, 0);
        check_frame(0, 1'b1, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
